// File: rtl/pattern_stim_pkg.sv
// Shared encodings, seeds and PRBS helper for pattern_stim_gen.
// The PRBS helper is only referenced when PATSTIM_PRBS_EN is defined.
package pattern_stim_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'b00,
        MODE_WALK  = 2'b01,
        MODE_PRBS  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [7:0] SEED_COUNT = 8'h00;
    localparam logic [7:0] SEED_WALK  = 8'h01;
    localparam logic [7:0] SEED_PRBS  = 8'h01;
    localparam logic [7:0] PRBS_TAPS  = 8'hB8;

    // Taps 7,5,4,3 give the maximal-length 255-state sequence.
    function automatic logic [7:0] prbs_next(input logic [7:0] q);
        return {q[6:0], ^(q & PRBS_TAPS)};
    endfunction

endpackage

// File: rtl/pattern_stim_gen_tick_divider.sv
// Down-counting rate divider: one-cycle tick every load_val+1 enabled cycles.
// clr reloads the counter so the first tick lands load_val+1 cycles later.
module tick_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? load_val : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattern_stim_gen.sv
// Stimulus source: count / walking-one / PRBS vectors at a programmable rate.
// Define PATSTIM_PRBS_EN to build the PRBS mode; otherwise mode 10 acts as count.
module pattern_stim_gen
    import pattern_stim_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIV_W   = 8,
    parameter int ONESHOT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] pattern_out,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH:0] N_COUNT = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] N_WALK  = (WIDTH+1)'(WIDTH);
`ifdef PATSTIM_PRBS_EN
    localparam logic [WIDTH:0] N_PRBS  = (WIDTH+1)'(255);
`endif

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d, mode_in;
    logic [DIV_W-1:0] div_q, div_d, load_val;
    logic [WIDTH-1:0] pat_q, pat_d, seed_in, nxt;
    logic [WIDTH:0]   cnt_q, cnt_d, n_len;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick, clr, run;

    assign run      = (state_q == ST_RUN);
    assign load_val = run ? div_q : div;

    tick_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (run),
        .load_val(load_val),
        .tick    (tick)
    );

    // Reserved and (when not built) PRBS encodings collapse onto count.
    always_comb begin
        mode_in = MODE_COUNT;
        if (mode == 2'b01) begin
            mode_in = MODE_WALK;
        end
`ifdef PATSTIM_PRBS_EN
        else if (mode == 2'b10) begin
            mode_in = MODE_PRBS;
        end
`endif
    end

    always_comb begin
        seed_in = WIDTH'(SEED_COUNT);
        case (mode_in)
            MODE_WALK: seed_in = WIDTH'(SEED_WALK);
`ifdef PATSTIM_PRBS_EN
            MODE_PRBS: seed_in = WIDTH'(SEED_PRBS);
`endif
            default:   seed_in = WIDTH'(SEED_COUNT);
        endcase
    end

    always_comb begin
        nxt   = pat_q + 1'b1;
        n_len = N_COUNT;
        case (mode_q)
            MODE_WALK: begin
                nxt   = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                n_len = N_WALK;
            end
`ifdef PATSTIM_PRBS_EN
            MODE_PRBS: begin
                nxt   = WIDTH'(prbs_next(8'(pat_q)));
                n_len = N_PRBS;
            end
`endif
            default: begin
                nxt   = pat_q + 1'b1;
                n_len = N_COUNT;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode_in;
                    div_d   = div;
                    pat_d   = seed_in;
                    cnt_d   = (WIDTH+1)'(1);
                    valid_d = 1'b1;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (cnt_q == n_len && ONESHOT != 0) begin
                        state_d = ST_DONE;
                    end else begin
                        pat_d   = nxt;
                        valid_d = 1'b1;
                        cnt_d   = (cnt_q == n_len) ? (WIDTH+1)'(1)
                                                   : cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COUNT;
            div_q   <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pattern_out   = pat_q;
    assign pattern_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pattern_stim_gen.sv
// Scoreboard bench for pattern_stim_gen: one-shot DUT plus a free-running DUT.
// Expected vectors are queued at stimulus time and popped on each valid pulse.
module tb_pattern_stim_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [1:0] mode;
    logic [7:0] div;
    logic [7:0] pat;
    logic       valid, busy, done;

    logic       f_start, f_stop;
    logic [1:0] f_mode;
    logic [7:0] f_div;
    logic [7:0] f_pat;
    logic       f_valid, f_busy, f_done;

    always #5 clk = ~clk;

    pattern_stim_gen #(.WIDTH(8), .DIV_W(8), .ONESHOT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .div          (div),
        .pattern_out  (pat),
        .pattern_valid(valid),
        .busy         (busy),
        .done         (done)
    );

    pattern_stim_gen #(.WIDTH(8), .DIV_W(8), .ONESHOT(0)) dut_free (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (f_start),
        .stop         (f_stop),
        .mode         (f_mode),
        .div          (f_div),
        .pattern_out  (f_pat),
        .pattern_valid(f_valid),
        .busy         (f_busy),
        .done         (f_done)
    );

    typedef struct {
        logic [7:0] v;
        int         gap;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] fq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_v = 0;
    int         f_rx = 0;
    bit         f_done_seen = 1'b0;
    bit         seen[256];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (valid === 1'b1) begin
            seen[pat] = 1'b1;
            if (sbq.size() == 0) begin
                chk("extra_valid", valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("vec", pat, e.v);
                if (e.gap != 0) chk("gap", cyc - last_v, e.gap);
            end
            last_v = cyc;
        end
        if (f_valid === 1'b1) begin
            f_rx++;
            if (fq.size() == 0) chk("f_extra_valid", f_valid, 0);
            else chk("f_vec", f_pat, fq.pop_front());
        end
        if (f_done === 1'b1) f_done_seen = 1'b1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v, input int gap);
        exp_t e;
        e.v   = v;
        e.gap = gap;
        sbq.push_back(e);
    endtask

    task automatic go(input logic [1:0] m, input logic [7:0] d);
        mode  = m;
        div   = d;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'b11;
        div   = 8'hFF;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("done_rise", done, 1);
    endtask

    initial begin
        logic [7:0] q;
        int         nz;
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 2'b00;
        div    = 8'd0;
        f_start = 1'b0;
        f_stop  = 1'b0;
        f_mode  = 2'b00;
        f_div   = 8'd0;
        repeat (3) step();
        chk("rst_pat", pat, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        // T1: reset mid-run
        push(8'h00, 0);
        go(2'b00, 8'd5);
        chk("t1_busy", busy, 1);
        step();
        rst_n = 1'b0;
        repeat (3) step();
        chk("t1_pat", pat, 0);
        chk("t1_valid", valid, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        rst_n = 1'b1;
        step();
        chk("t1_q", sbq.size(), 0);

        // T2: count, div=0
        for (int i = 0; i < 256; i++) push(8'(i), (i == 0) ? 0 : 1);
        go(2'b00, 8'd0);
        wait_done(400);
        chk("t2_pat", pat, 8'hFF);
        chk("t2_busy", busy, 0);
        chk("t2_q", sbq.size(), 0);
        repeat (5) step();
        chk("t2_hold", done, 1);

        // T3: walking one, div=2
        for (int i = 0; i < 8; i++) push(8'(1 << i), (i == 0) ? 0 : 3);
        go(2'b01, 8'd2);
        wait_done(100);
        chk("t3_pat", pat, 8'h80);
        chk("t3_q", sbq.size(), 0);

        // T4: PRBS or count fallback
        foreach (seen[i]) seen[i] = 1'b0;
`ifdef PATSTIM_PRBS_EN
        push(8'h01, 0);
        push(8'h02, 1);
        push(8'h04, 1);
        push(8'h08, 1);
        push(8'h11, 1);
        q = 8'h11;
        for (int i = 5; i < 255; i++) begin
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
            push(q, 1);
        end
        go(2'b10, 8'd0);
        wait_done(400);
        nz = 0;
        for (int i = 1; i < 256; i++) if (seen[i]) nz++;
        chk("t4_distinct", nz, 255);
        chk("t4_zero", seen[0], 0);
`else
        for (int i = 0; i < 256; i++) push(8'(i), (i == 0) ? 0 : 1);
        go(2'b10, 8'd0);
        wait_done(400);
        nz = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) nz++;
        chk("t4_distinct", nz, 256);
`endif
        chk("t4_q", sbq.size(), 0);

        // T5: restart from DONE, stop after 10 vectors
        for (int i = 0; i < 10; i++) push(8'(i), (i == 0) ? 0 : 1);
        go(2'b00, 8'd0);
        repeat (9) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_pat", pat, 8'h09);
        chk("t5_q", sbq.size(), 0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        step();
        chk("t5_ss_busy", busy, 0);
        chk("t5_ss_pat", pat, 8'h09);

        // T6: free-running wrap
        for (int i = 0; i < 256; i++) fq.push_back(8'(i));
        for (int i = 0; i < 10; i++) fq.push_back(8'(i));
        f_mode  = 2'b00;
        f_div   = 8'd0;
        f_start = 1'b1;
        step();
        f_start = 1'b0;
        for (int n = 0; n < 400 && f_rx < 261; n++) step();
        chk("t6_rx", f_rx >= 261, 1);
        chk("t6_busy", f_busy, 1);
        chk("t6_done", f_done_seen, 0);
        f_stop = 1'b1;
        step();
        f_stop = 1'b0;
        step();
        chk("t6_stop", f_busy, 0);
        fq.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
